// File: rtl/ara_pe_vinsn_queue.sv
// Per-PE vector instruction queue: buffers requests, waits out hazards on the head
// entry, then issues one element beat per datapath handshake and pulses completion.
module ara_pe_vinsn_queue #(
    parameter int NrVInsn    = 8,
    parameter int QueueDepth = 4,
    parameter int VlWidth    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pe_req_valid_i,
    output logic                       pe_req_ready_o,
    input  logic                       pe_req_for_me_i,
    input  logic [$clog2(NrVInsn)-1:0] pe_req_id_i,
    input  logic [VlWidth-1:0]         pe_req_vl_i,
    input  logic [NrVInsn-1:0]         pe_req_hazard_i,
    input  logic [NrVInsn-1:0]         vinsn_running_i,
    output logic                       exec_valid_o,
    input  logic                       exec_ready_i,
    output logic [$clog2(NrVInsn)-1:0] exec_id_o,
    output logic                       exec_last_o,
    output logic [NrVInsn-1:0]         vinsn_done_o,
    output logic                       busy_o
);

    localparam int IdW  = $clog2(NrVInsn);
    localparam int PtrW = $clog2(QueueDepth);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;

    localparam logic [VlWidth-1:0] VL_ONE  = {{(VlWidth-1){1'b0}}, 1'b1};
    localparam logic [NrVInsn-1:0] ID_ONE  = {{(NrVInsn-1){1'b0}}, 1'b1};
    localparam logic [PtrW:0]      PTR_ONE = {{PtrW{1'b0}}, 1'b1};

    logic [IdW-1:0]     r_q_id  [QueueDepth];
    logic [VlWidth-1:0] r_q_vl  [QueueDepth];
    logic [NrVInsn-1:0] r_q_haz [QueueDepth];
    logic [PtrW:0]      r_wr_ptr;
    logic [PtrW:0]      r_rd_ptr;
    logic [NrVInsn-1:0] r_held;
    logic [VlWidth-1:0] r_cnt;
    logic [1:0]         r_state;
    logic [NrVInsn-1:0] r_done;

    logic [PtrW-1:0]    w_wr_idx;
    logic [PtrW-1:0]    w_rd_idx;
    logic               w_empty;
    logic               w_full;
    logic [IdW-1:0]     w_head_id;
    logic               w_exec_valid;
    logic               w_hs;
    logic               w_pop;
    logic               w_push;
    logic [NrVInsn-1:0] w_new_haz;
    logic [PtrW:0]      w_wr_ptr_nxt;
    logic [PtrW:0]      w_rd_ptr_nxt;
    logic [PtrW-1:0]    w_nh_idx;
    logic [VlWidth-1:0] w_nh_vl;
    logic [NrVInsn-1:0] w_nh_haz;
    logic [1:0]         w_state_nxt;
    logic               w_load;
    logic [NrVInsn-1:0] w_done_nxt;
    logic [NrVInsn-1:0] w_held_nxt;

    assign w_wr_idx  = r_wr_ptr[PtrW-1:0];
    assign w_rd_idx  = r_rd_ptr[PtrW-1:0];
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]);
    assign w_head_id = r_q_id[w_rd_idx];

    // A zero-length head sits in EXEC with a zero count and retires without a beat.
    assign w_exec_valid = (r_state == ST_EXEC) && (|r_cnt);
    assign w_hs         = w_exec_valid && exec_ready_i;
    assign w_pop        = (r_state == ST_EXEC) && ((w_hs && (r_cnt == VL_ONE)) || !(|r_cnt));
    assign w_push       = pe_req_valid_i && !w_full && pe_req_for_me_i && !r_held[pe_req_id_i];
    assign w_new_haz    = pe_req_hazard_i & vinsn_running_i;

    assign w_wr_ptr_nxt = w_push ? r_wr_ptr + PTR_ONE : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + PTR_ONE : r_rd_ptr;
    assign w_nh_idx     = w_rd_ptr_nxt[PtrW-1:0];

    // Next state is derived from what the head registers will hold after this edge,
    // so a hazard clearing this cycle or a fresh accept issues without a bubble.
    always_comb begin
        w_nh_vl  = r_q_vl[w_nh_idx];
        w_nh_haz = r_q_haz[w_nh_idx] & vinsn_running_i;
        if (w_push && (w_nh_idx == w_wr_idx)) begin
            w_nh_vl  = pe_req_vl_i;
            w_nh_haz = w_new_haz;
        end
        if (w_rd_ptr_nxt == w_wr_ptr_nxt) begin
            w_state_nxt = ST_IDLE;
        end else if (|w_nh_haz) begin
            w_state_nxt = ST_WAIT;
        end else begin
            w_state_nxt = ST_EXEC;
        end
    end

    assign w_load     = (w_state_nxt == ST_EXEC) && ((r_state != ST_EXEC) || w_pop);
    assign w_done_nxt = w_pop ? (ID_ONE << w_head_id) : '0;
    assign w_held_nxt = (r_held & ~w_done_nxt) | (w_push ? (ID_ONE << pe_req_id_i) : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < QueueDepth; i++) begin
                r_q_id[i]  <= '0;
                r_q_vl[i]  <= '0;
                r_q_haz[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_held   <= '0;
            r_cnt    <= '0;
            r_state  <= ST_IDLE;
            r_done   <= '0;
        end else begin
            for (int i = 0; i < QueueDepth; i++) begin
                r_q_haz[i] <= r_q_haz[i] & vinsn_running_i;
            end
            if (w_push) begin
                r_q_id[w_wr_idx]  <= pe_req_id_i;
                r_q_vl[w_wr_idx]  <= pe_req_vl_i;
                r_q_haz[w_wr_idx] <= w_new_haz;
            end
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_held   <= w_held_nxt;
            r_state  <= w_state_nxt;
            r_done   <= w_done_nxt;
            if (w_load) begin
                r_cnt <= w_nh_vl;
            end else if (w_hs) begin
                r_cnt <= r_cnt - VL_ONE;
            end
        end
    end

    assign pe_req_ready_o = !w_full;
    assign exec_valid_o   = w_exec_valid;
    assign exec_id_o      = (r_state == ST_EXEC) ? w_head_id : '0;
    assign exec_last_o    = (r_state == ST_EXEC) && (r_cnt == VL_ONE);
    assign vinsn_done_o   = r_done;
    assign busy_o         = !w_empty || (|r_done);

endmodule

// File: tb/tb_ara_pe_vinsn_queue.sv
// Directed bench for ara_pe_vinsn_queue with default parameters (8 IDs, depth 4).
module tb_ara_pe_vinsn_queue;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       pe_req_valid_i;
    logic       pe_req_ready_o;
    logic       pe_req_for_me_i;
    logic [2:0] pe_req_id_i;
    logic [15:0] pe_req_vl_i;
    logic [7:0] pe_req_hazard_i;
    logic [7:0] vinsn_running_i;
    logic       exec_valid_o;
    logic       exec_ready_i;
    logic [2:0] exec_id_o;
    logic       exec_last_o;
    logic [7:0] vinsn_done_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    ara_pe_vinsn_queue #(.NrVInsn(8), .QueueDepth(4), .VlWidth(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pe_req_valid_i (pe_req_valid_i),
        .pe_req_ready_o (pe_req_ready_o),
        .pe_req_for_me_i(pe_req_for_me_i),
        .pe_req_id_i    (pe_req_id_i),
        .pe_req_vl_i    (pe_req_vl_i),
        .pe_req_hazard_i(pe_req_hazard_i),
        .vinsn_running_i(vinsn_running_i),
        .exec_valid_o   (exec_valid_o),
        .exec_ready_i   (exec_ready_i),
        .exec_id_o      (exec_id_o),
        .exec_last_o    (exec_last_o),
        .vinsn_done_o   (vinsn_done_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [2:0] id, input logic [15:0] vl, input logic [7:0] haz);
        pe_req_valid_i  = 1'b1;
        pe_req_for_me_i = 1'b1;
        pe_req_id_i     = id;
        pe_req_vl_i     = vl;
        pe_req_hazard_i = haz;
    endtask

    initial begin
        rst_i = 1'b1;
        pe_req_valid_i = 1'b0;
        pe_req_for_me_i = 1'b0;
        pe_req_id_i = '0;
        pe_req_vl_i = '0;
        pe_req_hazard_i = '0;
        vinsn_running_i = '0;
        exec_ready_i = 1'b0;
        step();
        step();
        chk("rst_ready", pe_req_ready_o, 1);
        chk("rst_valid", exec_valid_o, 0);
        chk("rst_id", exec_id_o, 0);
        chk("rst_last", exec_last_o, 0);
        chk("rst_done", vinsn_done_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b0;

        // id 3, vl 4, no hazard: beats t+1..t+4, done at t+5
        exec_ready_i = 1'b1;
        req(3, 4, 8'h00);
        chk("t1_ready", pe_req_ready_o, 1);
        step();
        pe_req_valid_i = 1'b0;
        chk("t1_b1_valid", exec_valid_o, 1);
        chk("t1_b1_id", exec_id_o, 3);
        chk("t1_b1_last", exec_last_o, 0);
        step();
        chk("t1_b2_valid", exec_valid_o, 1);
        chk("t1_b2_last", exec_last_o, 0);
        step();
        chk("t1_b3_valid", exec_valid_o, 1);
        chk("t1_b3_last", exec_last_o, 0);
        step();
        chk("t1_b4_valid", exec_valid_o, 1);
        chk("t1_b4_id", exec_id_o, 3);
        chk("t1_b4_last", exec_last_o, 1);
        step();
        chk("t1_done_valid", exec_valid_o, 0);
        chk("t1_done", vinsn_done_o, 8'h08);
        chk("t1_done_busy", busy_o, 1);
        step();
        chk("t1_after_done", vinsn_done_o, 0);
        chk("t1_after_busy", busy_o, 0);

        // request not for this PE is never stored
        req(7, 3, 8'h00);
        pe_req_for_me_i = 1'b0;
        step();
        pe_req_valid_i = 1'b0;
        pe_req_for_me_i = 1'b1;
        chk("nfm_valid", exec_valid_o, 0);
        chk("nfm_busy", busy_o, 0);
        step();
        chk("nfm_valid2", exec_valid_o, 0);

        // hazard on id 0 held, then released
        vinsn_running_i = 8'h01;
        req(2, 2, 8'h01);
        step();
        pe_req_valid_i = 1'b0;
        chk("haz_wait_valid", exec_valid_o, 0);
        chk("haz_wait_busy", busy_o, 1);
        step();
        chk("haz_wait_valid2", exec_valid_o, 0);
        vinsn_running_i = 8'h00;
        chk("haz_drop_valid", exec_valid_o, 0);
        step();
        chk("haz_exec_valid", exec_valid_o, 1);
        chk("haz_exec_id", exec_id_o, 2);
        chk("haz_exec_last", exec_last_o, 0);
        step();
        chk("haz_exec_last2", exec_last_o, 1);
        step();
        chk("haz_done", vinsn_done_o, 8'h04);
        chk("haz_done_valid", exec_valid_o, 0);
        step();

        // re-presented held ID is dropped: exactly one entry for id 5
        exec_ready_i = 1'b0;
        req(5, 1, 8'h00);
        repeat (6) step();
        pe_req_valid_i = 1'b0;
        chk("hold_valid", exec_valid_o, 1);
        chk("hold_id", exec_id_o, 5);
        chk("hold_last", exec_last_o, 1);
        chk("hold_ready", pe_req_ready_o, 1);
        exec_ready_i = 1'b1;
        step();
        chk("hold_done", vinsn_done_o, 8'h20);
        chk("hold_after_valid", exec_valid_o, 0);
        step();
        chk("hold_done_clear", vinsn_done_o, 0);
        chk("hold_busy", busy_o, 0);
        chk("hold_valid_end", exec_valid_o, 0);

        // fill the queue, then pop while full with a pending request
        exec_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req(3'(k), 1, 8'h00);
            step();
        end
        req(4, 1, 8'h00);
        chk("full_ready", pe_req_ready_o, 0);
        chk("full_head", exec_id_o, 0);
        exec_ready_i = 1'b1;
        step();
        pe_req_valid_i = 1'b0;
        chk("full_ready_after", pe_req_ready_o, 1);
        chk("full_done0", vinsn_done_o, 8'h01);
        chk("full_head1", exec_id_o, 1);
        chk("full_head1_valid", exec_valid_o, 1);
        step();
        chk("full_done1", vinsn_done_o, 8'h02);
        chk("full_head2", exec_id_o, 2);
        step();
        chk("full_done2", vinsn_done_o, 8'h04);
        chk("full_head3", exec_id_o, 3);
        step();
        chk("full_done3", vinsn_done_o, 8'h08);
        chk("full_no_id4", exec_valid_o, 0);
        step();
        chk("full_busy_end", busy_o, 0);

        // simultaneous accept and pop
        req(0, 1, 8'h00);
        step();
        req(1, 1, 8'h00);
        chk("sim_head0", exec_id_o, 0);
        chk("sim_valid0", exec_valid_o, 1);
        step();
        pe_req_valid_i = 1'b0;
        chk("sim_done0", vinsn_done_o, 8'h01);
        chk("sim_head1", exec_id_o, 1);
        chk("sim_valid1", exec_valid_o, 1);
        step();
        chk("sim_done1", vinsn_done_o, 8'h02);
        chk("sim_valid_end", exec_valid_o, 0);
        step();

        // zero-length instruction
        req(1, 0, 8'h00);
        step();
        pe_req_valid_i = 1'b0;
        chk("vl0_valid", exec_valid_o, 0);
        chk("vl0_done_early", vinsn_done_o, 0);
        chk("vl0_busy", busy_o, 1);
        step();
        chk("vl0_done", vinsn_done_o, 8'h02);
        chk("vl0_valid2", exec_valid_o, 0);
        step();
        chk("vl0_done_clear", vinsn_done_o, 0);
        chk("vl0_busy_end", busy_o, 0);

        // reset in the middle of executing id 6
        req(6, 8, 8'h00);
        step();
        pe_req_valid_i = 1'b0;
        chk("abort_valid", exec_valid_o, 1);
        chk("abort_id", exec_id_o, 6);
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("abort_rst_valid", exec_valid_o, 0);
        chk("abort_rst_id", exec_id_o, 0);
        chk("abort_rst_last", exec_last_o, 0);
        chk("abort_rst_done", vinsn_done_o, 0);
        chk("abort_rst_busy", busy_o, 0);
        chk("abort_rst_ready", pe_req_ready_o, 1);
        step();
        chk("abort_no_done", vinsn_done_o, 0);
        chk("abort_idle_valid", exec_valid_o, 0);
        chk("abort_idle_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ara_pe_vinsn_queue.md
ARA_PE_VINSN_QUEUE -- requirements
Module: ara_pe_vinsn_queue

Interface
REQ-001 SHALL have parameter NrVInsn, default 8, number of vector instruction IDs (power of 2, >=2).
REQ-002 SHALL have parameter QueueDepth, default 4, buffered instructions (power of 2, >=2).
REQ-003 SHALL have parameter VlWidth, default 16, width of the vl field.
REQ-004 SHALL have port clk_i  input  1  clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port pe_req_valid_i  input  1  sequencer request valid.
REQ-007 SHALL have port pe_req_ready_o  output  1  this PE can take a request.
REQ-008 SHALL have port pe_req_for_me_i  input  1  request targets this PE.
REQ-009 SHALL have port pe_req_id_i  input  $clog2(NrVInsn)  instruction ID.
REQ-010 SHALL have port pe_req_vl_i  input  VlWidth  element count.
REQ-011 SHALL have port pe_req_hazard_i  input  NrVInsn  OR of all hazard masks of the request.
REQ-012 SHALL have port vinsn_running_i  input  NrVInsn  broadcast of IDs running in Ara.
REQ-013 SHALL have port exec_valid_o  output  1  element beat offered to datapath.
REQ-014 SHALL have port exec_ready_i  input  1  datapath consumes beat.
REQ-015 SHALL have port exec_id_o  output  $clog2(NrVInsn)  ID of current beat.
REQ-016 SHALL have port exec_last_o  output  1  current beat is the last of its instruction.
REQ-017 SHALL have port vinsn_done_o  output  NrVInsn  one-hot, one-cycle completion pulse.
REQ-018 SHALL have port busy_o  output  1  queue non-empty or done pulse pending.

Function
REQ-019 pe_req_ready_o SHALL equal !full, independent of pe_req_valid_i and pe_req_for_me_i; no push when full even if the head pops in the same cycle.
REQ-020 Accept SHALL occur when pe_req_valid_i && pe_req_ready_o && pe_req_for_me_i && held_mask[pe_req_id_i]==0; the entry (id, vl, hazard & vinsn_running_i) is written at the tail.
REQ-021 held_mask SHALL have bit id set on accept and cleared on completion; a request re-presented with a held ID (sequencer stall) SHALL be dropped silently.
REQ-022 Requests with pe_req_for_me_i=0 SHALL never be stored.
REQ-023 Every stored hazard mask SHALL be ANDed with vinsn_running_i each cycle.
REQ-024 Head control FSM states: IDLE (empty), WAIT_HAZ (head hazard!=0), EXEC (issuing beats); FSM is a function of registered state only.
REQ-025 IDLE->WAIT_HAZ or EXEC the cycle after the first accept; WAIT_HAZ->EXEC the cycle after the head mask reaches 0.
REQ-026 EXEC: exec_valid_o=1, exec_id_o=head id; beat counter loads head vl on entering EXEC and decrements by 1 per exec_valid_o && exec_ready_i.
REQ-027 exec_last_o SHALL be 1 when remaining count ==1.
REQ-028 On last-beat handshake: head popped, held bit cleared, vinsn_done_o[id] pulses the next cycle for exactly 1 cycle; FSM moves to next head (EXEC/WAIT_HAZ) or IDLE in that same next cycle (no bubble).
REQ-029 vl==0: no beat issued, exec_valid_o stays 0; instruction completes the cycle its hazard mask is 0 (pop, done pulse next cycle).
REQ-030 Minimum latency: accept at cycle t, hazard-free, -> exec_valid_o=1 at t+1.
REQ-031 exec_valid_o SHALL stay high with stable exec_id_o/exec_last_o until handshake.
REQ-032 Simultaneous accept and pop when not full SHALL both take effect; occupancy unchanged.
REQ-033 Pointers SHALL wrap modulo QueueDepth; full/empty via extra pointer MSB or counter.

Reset
REQ-034 rst_i high SHALL, at the next edge, clear queue, pointers, held_mask, beat counter, FSM to IDLE, regardless of operation in progress.
REQ-035 Reset values: pe_req_ready_o=1, exec_valid_o=0, exec_id_o=0, exec_last_o=0, vinsn_done_o=0, busy_o=0; no done pulse for aborted instructions.

Verification
REQ-036 Accept id=3 vl=4 hazard=0 -> exec beats cycles t+1..t+4 (ready=1), exec_last_o on 4th, vinsn_done_o=8'h08 at t+5 only.
REQ-037 id=2 vl=2 hazard=8'h01, vinsn_running_i bit0 drops at cycle 10 -> exec_valid_o first high at 11.
REQ-038 Hold valid with id=5 for 6 cycles, for_me=1 -> exactly one entry, one done pulse 8'h20.
REQ-039 Fill 4 entries -> ready=0; pop during full while valid -> no push that cycle, ready=1 next.
REQ-040 id=1 vl=0 hazard=0 -> no exec beat, vinsn_done_o=8'h02 two cycles after accept.
REQ-041 rst_i mid-EXEC of id=6 -> all outputs at reset values next cycle, no done pulse for id 6.
